// File: rtl/seq_alu_if.sv
// Purpose : operation request / completion bundle between a requester and seq_alu.
// Latency : wires only, no storage.
// Backpressure: requester must hold off START while BUSY is high (seq_alu drops it).
// Ports   : START/SELECT/DATA1/DATA2 requester->ALU; RESULT/ZERO/CARRY/BUSY/DONE ALU->requester.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [2:0]       SELECT;
   logic [WIDTH-1:0] DATA1;
   logic [WIDTH-1:0] DATA2;
   logic [WIDTH-1:0] RESULT;
   logic             ZERO;
   logic             CARRY;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, SELECT, DATA1, DATA2,
      input  RESULT, ZERO, CARRY, BUSY, DONE
   );

   modport slave (
      input  START, SELECT, DATA1, DATA2,
      output RESULT, ZERO, CARRY, BUSY, DONE
   );
endinterface

// File: rtl/seq_alu.sv
// Purpose : multi-cycle ALU (fwd/add/and/or/sub/mult/sll/sra) with IDLE/EXEC/DONE FSM.
// Latency : result at START edge + L (L=1, WIDTH for MULT, max(1,min(DATA2,WIDTH)) for shifts), DONE next cycle.
// Backpressure: START is only sampled in IDLE; requests while BUSY are dropped, never queued.
// Ports   : CLK, RESET (sync, active high); bus = seq_alu_if slave (request in, result/flags/status out).
module seq_alu #(
   parameter int WIDTH = 8
) (
   input logic     CLK,
   input logic     RESET,
   seq_alu_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t           r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;      // MULT partial sum, or shift working value
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic             r_sh_en;    // shift amount non-zero; a zero shift still spends one cycle
   logic [CW-1:0]    r_cnt;      // remaining EXEC cycles minus one
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_carry;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic [WIDTH-1:0] w_mul;
   logic [WIDTH-1:0] w_shf;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic [CW-1:0]    w_s;
   logic [CW-1:0]    w_cnt_init;

   // Datapath step for the current EXEC cycle; on the last cycle w_res is the final value.
   always_comb begin
      w_sum = {1'b0, r_a} + {1'b0, r_b};
      w_dif = {1'b0, r_a} - {1'b0, r_b};   // bit WIDTH is the borrow
      w_mul = r_acc + (r_mplier[0] ? r_mcand : '0);
      if (!r_sh_en)
         w_shf = r_acc;
      else if (r_op == OP_SRA)
         w_shf = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      else
         w_shf = {r_acc[WIDTH-2:0], 1'b0};
      w_res   = '0;
      w_carry = 1'b0;
      case (r_op)
         OP_FWD: w_res = r_b;
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
         end
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_SUB: begin
            w_res   = w_dif[WIDTH-1:0];
            w_carry = w_dif[WIDTH];
         end
         OP_MUL: w_res = w_mul;
         default: w_res = w_shf;
      endcase
   end

   // EXEC length from the request being accepted; shift amounts saturate at WIDTH.
   always_comb begin
      w_s = (bus.DATA2 >= W_LIM) ? CW'(WIDTH) : CW'(bus.DATA2);
      w_cnt_init = '0;
      if (bus.SELECT == OP_MUL)
         w_cnt_init = CW'(WIDTH - 1);
      else if (bus.SELECT[2:1] == 2'b11 && w_s != '0)
         w_cnt_init = w_s - CW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_op     <= OP_FWD;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_sh_en  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_carry  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.START) begin
                  r_op     <= bus.SELECT;
                  r_a      <= bus.DATA1;
                  r_b      <= bus.DATA2;
                  r_mcand  <= bus.DATA1;
                  r_mplier <= bus.DATA2;
                  r_acc    <= (bus.SELECT == OP_MUL) ? '0 : bus.DATA1;
                  r_sh_en  <= (bus.DATA2 != '0);
                  r_cnt    <= w_cnt_init;
                  r_busy   <= 1'b1;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_acc    <= (r_op == OP_MUL) ? w_mul : w_shf;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (r_cnt == '0) begin
                  r_result <= w_res;
                  r_zero   <= (w_res == '0);
                  r_carry  <= w_carry;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.RESULT = r_result;
   assign bus.ZERO   = r_zero;
   assign bus.CARRY  = r_carry;
   assign bus.BUSY   = r_busy;
   assign bus.DONE   = r_done;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port START, input, 1, request to begin an operation.
REQ-005 The block SHALL have port SELECT, input, 3, opcode.
REQ-006 The block SHALL have ports DATA1 and DATA2, input, WIDTH each, operands.
REQ-007 The block SHALL have port RESULT, output, WIDTH, registered result.
REQ-008 The block SHALL have port ZERO, output, 1, registered flag, 1 when RESULT is all zeros.
REQ-009 The block SHALL have port CARRY, output, 1, registered carry-out (ADD) or borrow (SUB), else 0.
REQ-010 The block SHALL have port BUSY, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port DONE, output, 1, one-cycle completion pulse.

Function
REQ-012 Opcodes SHALL be: 000 FORWARD (DATA2), 001 ADD, 010 AND, 011 OR, 100 SUB (DATA1-DATA2), 101 MULT (low WIDTH bits of unsigned product), 110 SLL (DATA1 << DATA2), 111 SRA (DATA1 >>> DATA2, sign fill).
REQ-013 The FSM SHALL have states IDLE, EXEC and DONE; transitions are IDLE->EXEC on START, EXEC->DONE when the iteration count expires, and DONE->IDLE unconditionally.
REQ-014 START SHALL be sampled only in IDLE; on that edge SELECT, DATA1 and DATA2 are latched internally, and later input changes do not affect the operation.
REQ-015 START asserted in EXEC or DONE SHALL be ignored, with no queuing.
REQ-016 EXEC SHALL last 1 cycle for opcodes 000-100, WIDTH cycles for MULT (one shift-add step per cycle), and max(1, s) cycles for shifts, where s = min(DATA2, WIDTH) and one bit position is shifted per cycle.
REQ-017 For START sampled at edge N with EXEC length L, RESULT, ZERO and CARRY SHALL update at edge N+L, and DONE SHALL be 1 for exactly the cycle after that edge.
REQ-018 RESULT, ZERO and CARRY SHALL hold their values until the next completion and SHALL NOT show intermediate MULT or shift values.
REQ-019 ADD CARRY SHALL be bit WIDTH of the (WIDTH+1)-bit sum; SUB CARRY SHALL be 1 iff DATA1 < DATA2 unsigned; results wrap modulo 2^WIDTH.
REQ-020 A shift amount of WIDTH or more SHALL saturate: SLL yields 0, SRA yields all copies of the DATA1 sign bit.
REQ-021 A shift amount of 0 SHALL take 1 EXEC cycle and return DATA1 unchanged.
REQ-022 ZERO SHALL be derived from the value being written to RESULT on the same edge.
REQ-023 START SHALL be accepted again on the first cycle after DONE, giving back-to-back single-cycle operations every 3 cycles.

Reset
REQ-024 At a rising edge with RESET=1, the FSM SHALL go to IDLE, RESULT=0, ZERO=1, CARRY=0, DONE=0, BUSY=0, and internal counters and accumulators SHALL clear.
REQ-025 RESET SHALL take priority over START and over any in-flight operation; an aborted operation SHALL produce no DONE.
REQ-026 START SHALL be accepted on the first edge after RESET deasserts.

Verification (WIDTH=8)
REQ-027 Reset then idle -> RESULT=8'h00, ZERO=1, CARRY=0, BUSY=0, DONE=0; ADD 8'hF0+8'h20 START at edge N -> RESULT=8'h10, CARRY=1, ZERO=0, DONE high only in the cycle after edge N+1.
REQ-028 SUB 8'd5-8'd5 -> RESULT=0, ZERO=1, CARRY=0; then SUB 8'd3-8'd5 -> RESULT=8'hFE, CARRY=1, ZERO=0.
REQ-029 MULT 8'd13*8'd11 -> RESULT=8'h8F after 8 EXEC cycles, BUSY high 9 cycles; a START with ADD pulsed mid-operation is ignored and RESULT is unchanged until DONE.
REQ-030 SRA 8'h90 by 2 -> 8'hE4 after 2 EXEC cycles; SLL 8'h81 by 9 -> 8'h00, ZERO=1, after 8 EXEC cycles; SLL 8'h5A by 0 -> 8'h5A after 1 cycle.
REQ-031 RESET asserted at EXEC cycle 4 of MULT -> all outputs at reset values next cycle with no DONE pulse; a new OR 8'h0F|8'hF0 after reset -> 8'hFF.
